// File: rtl/fp_operand_classify.sv
// fp_operand_classify: two-stage operand pre-processor for the floating-point
// datapath. Classifies both operands, resolves special-case results for
// multiply (MODE=0) or add (MODE=1), forms the pre-biased exponent term and
// keeps sticky invalid/NaN flags. Valid/ready handshake with backpressure.
module fp_operand_classify #(
   parameter int WEXP     = 8,
   parameter int WSIG     = 23,
   parameter int WCONTROL = 5,
   parameter int MODE     = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [WEXP+WSIG:0]     a,
   input  logic [WEXP+WSIG:0]     b,
   input  logic                   sub,
   input  logic [WCONTROL-1:0]    control,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [5:0]             aclass,
   output logic [5:0]             bclass,
   output logic                   sign,
   output logic [WEXP+1:0]        exp_term,
   output logic [1:0]             roundmode,
   output logic                   res_special,
   output logic                   res_nan,
   output logic                   res_inf,
   output logic                   res_zero,
   output logic                   invalid,
   output logic                   sticky_invalid,
   output logic                   sticky_nan,
   input  logic                   clr_flags
);

   // Bias expressed in the WEXP+2-bit two's-complement domain of exp_term
   localparam logic [WEXP+1:0] BIAS_T = {3'b000, {(WEXP-1){1'b1}}};

   // One-hot class {snan, qnan, inf, normal, denorm, zero}
   function automatic logic [5:0] classify(input logic [WEXP-1:0] e,
                                           input logic [WSIG-1:0] s);
      logic [5:0] c;
      c = 6'b000100;
      if (e == '0) begin
         c = (s == '0) ? 6'b000001 : 6'b000010;
      end else if (&e) begin
         if (s == '0)
            c = 6'b001000;
         else if (s[WSIG-1])
            c = 6'b010000;
         else
            c = 6'b100000;
      end
      return c;
   endfunction

   // Denormals use an effective exponent of 1, zero-extended into the wide domain
   function automatic logic [WEXP+1:0] eprime(input logic [WEXP-1:0] e);
      return (e == '0) ? {{(WEXP+1){1'b0}}, 1'b1} : {2'b00, e};
   endfunction

   logic                v1;
   logic                v2;
   logic [5:0]          ac1;
   logic [5:0]          bc1;
   logic                sign1;
   logic [WEXP-1:0]     ea1;
   logic [WEXP-1:0]     eb1;
   logic [WCONTROL-1:0] ctrl1;

   logic                load1;
   logic                load2;
   logic                sign_in;
   logic                nan_n;
   logic                inf_n;
   logic                zero_n;
   logic                inv_n;
   logic [WEXP+1:0]     exp_n;
   logic                unused_bits;

   // Only the round-mode bits of the control word travel downstream; sub
   // has no meaning in multiply mode.
   assign unused_bits = ^{ctrl1, sub};

   // Handshake: stage 2 drains when empty or accepted downstream, and the
   // input is ready exactly when stage 1 is empty or will move this edge.
   always_comb begin
      load2    = v1 & (~v2 | out_ready);
      in_ready = ~v1 | ~v2 | out_ready;
      load1    = in_valid & in_ready;
      sign_in  = a[WEXP+WSIG] ^ b[WEXP+WSIG];
      if (MODE == 1)
         sign_in = a[WEXP+WSIG] ^ b[WEXP+WSIG] ^ sub;
   end

   // Stage 1: classes, sign, raw exponents and control word
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         ac1   <= '0;
         bc1   <= '0;
         sign1 <= 1'b0;
         ea1   <= '0;
         eb1   <= '0;
         ctrl1 <= '0;
      end else begin
         if (load1) begin
            v1    <= 1'b1;
            ac1   <= classify(a[WEXP+WSIG-1:WSIG], a[WSIG-1:0]);
            bc1   <= classify(b[WEXP+WSIG-1:WSIG], b[WSIG-1:0]);
            sign1 <= sign_in;
            ea1   <= a[WEXP+WSIG-1:WSIG];
            eb1   <= b[WEXP+WSIG-1:WSIG];
            ctrl1 <= control;
         end else if (load2) begin
            v1 <= 1'b0;
         end
      end
   end

   // Special-case resolution and exponent term from the stage-1 contents
   always_comb begin
      nan_n  = 1'b0;
      inf_n  = 1'b0;
      zero_n = 1'b0;
      inv_n  = 1'b0;
      if (MODE == 0) begin
         exp_n = eprime(ea1) + eprime(eb1) - BIAS_T;
         if (ac1[5] | ac1[4] | bc1[5] | bc1[4]) begin
            nan_n = 1'b1;
         end else if ((ac1[0] & bc1[3]) | (ac1[3] & bc1[0])) begin
            nan_n = 1'b1;
            inv_n = 1'b1;
         end else if (ac1[3] | bc1[3]) begin
            inf_n = 1'b1;
         end else if (ac1[0] | bc1[0]) begin
            zero_n = 1'b1;
         end
      end else begin
         exp_n = eprime(ea1) - eprime(eb1);
         if (ac1[5] | ac1[4] | bc1[5] | bc1[4]) begin
            nan_n = 1'b1;
         end else if (ac1[3] & bc1[3] & sign1) begin
            nan_n = 1'b1;
            inv_n = 1'b1;
         end else if (ac1[3] | bc1[3]) begin
            inf_n = 1'b1;
         end else if (ac1[0] & bc1[0]) begin
            zero_n = 1'b1;
         end
      end
      if (ac1[5] | bc1[5])
         inv_n = 1'b1;
   end

   // Stage 2: registered outputs, held while stalled downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v2          <= 1'b0;
         aclass      <= '0;
         bclass      <= '0;
         sign        <= 1'b0;
         exp_term    <= '0;
         roundmode   <= '0;
         res_special <= 1'b0;
         res_nan     <= 1'b0;
         res_inf     <= 1'b0;
         res_zero    <= 1'b0;
         invalid     <= 1'b0;
      end else begin
         if (load2) begin
            v2          <= 1'b1;
            aclass      <= ac1;
            bclass      <= bc1;
            sign        <= sign1;
            exp_term    <= exp_n;
            roundmode   <= ctrl1[1:0];
            res_special <= nan_n | inf_n | zero_n;
            res_nan     <= nan_n;
            res_inf     <= inf_n;
            res_zero    <= zero_n;
            invalid     <= inv_n;
         end else if (out_ready) begin
            v2 <= 1'b0;
         end
      end
   end

   assign out_valid = v2;

   // Sticky flags accumulate on output handshakes; a set beats a same-edge clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_invalid <= 1'b0;
         sticky_nan     <= 1'b0;
      end else begin
         sticky_invalid <= (sticky_invalid & ~clr_flags) | (v2 & out_ready & invalid);
         sticky_nan     <= (sticky_nan & ~clr_flags) | (v2 & out_ready & res_nan);
      end
   end

endmodule

// File: tb/tb_fp_operand_classify.sv
// tb_fp_operand_classify: scoreboard bench driving a multiply-mode and an
// add-mode instance with the same operand stream.
module tb_fp_operand_classify;

   typedef struct packed {
      logic [5:0] ac;
      logic [5:0] bc;
      logic       sg;
      logic [9:0] et;
      logic [1:0] rm;
      logic       sp;
      logic       nan;
      logic       inf;
      logic       zero;
      logic       inv;
   } res_t;

   typedef struct packed {
      res_t mul;
      res_t add;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic [31:0] a;
   logic [31:0] b;
   logic        sub;
   logic [4:0]  control;
   logic        out_ready;
   logic        clr_flags;

   logic        in_ready_m, out_valid_m, si_m, sn_m;
   logic [5:0]  ac_m, bc_m;
   logic        sg_m, sp_m, nan_m, inf_m, zero_m, inv_m;
   logic [9:0]  et_m;
   logic [1:0]  rm_m;

   logic        in_ready_a, out_valid_a, si_a, sn_a;
   logic [5:0]  ac_a, bc_a;
   logic        sg_a, sp_a, nan_a, inf_a, zero_a, inv_a;
   logic [9:0]  et_a;
   logic [1:0]  rm_a;

   res_t        mul_obs;
   res_t        add_obs;
   res_t        prev_mul;
   res_t        prev_add;
   logic        stalled_prev = 1'b0;

   exp_t        sbq[$];
   int          checks = 0;
   int          errors = 0;
   int          pops = 0;
   logic        m_si_m = 1'b0, m_sn_m = 1'b0, m_si_a = 1'b0, m_sn_a = 1'b0;
   logic [31:0] pool [0:9];

   always #5 clk = ~clk;

   fp_operand_classify #(.WEXP(8), .WSIG(23), .WCONTROL(5), .MODE(0)) dut_mul (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_m),
      .a(a), .b(b), .sub(sub), .control(control),
      .out_valid(out_valid_m), .out_ready(out_ready),
      .aclass(ac_m), .bclass(bc_m), .sign(sg_m), .exp_term(et_m), .roundmode(rm_m),
      .res_special(sp_m), .res_nan(nan_m), .res_inf(inf_m), .res_zero(zero_m),
      .invalid(inv_m), .sticky_invalid(si_m), .sticky_nan(sn_m), .clr_flags(clr_flags)
   );

   fp_operand_classify #(.WEXP(8), .WSIG(23), .WCONTROL(5), .MODE(1)) dut_add (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
      .a(a), .b(b), .sub(sub), .control(control),
      .out_valid(out_valid_a), .out_ready(out_ready),
      .aclass(ac_a), .bclass(bc_a), .sign(sg_a), .exp_term(et_a), .roundmode(rm_a),
      .res_special(sp_a), .res_nan(nan_a), .res_inf(inf_a), .res_zero(zero_a),
      .invalid(inv_a), .sticky_invalid(si_a), .sticky_nan(sn_a), .clr_flags(clr_flags)
   );

   assign mul_obs = {ac_m, bc_m, sg_m, et_m, rm_m, sp_m, nan_m, inf_m, zero_m, inv_m};
   assign add_obs = {ac_a, bc_a, sg_a, et_a, rm_a, sp_a, nan_a, inf_a, zero_a, inv_a};

   // Reference class of a binary32 operand
   function automatic logic [5:0] ref_class(input logic [31:0] x);
      logic [7:0]  e;
      logic [22:0] m;
      e = x[30:23];
      m = x[22:0];
      if (e == 8'd0 && m == 23'd0) return 6'b000001;
      if (e == 8'd0)               return 6'b000010;
      if (e != 8'hFF)              return 6'b000100;
      if (m == 23'd0)              return 6'b001000;
      if (m[22])                   return 6'b010000;
      return 6'b100000;
   endfunction

   // Reference result for one operand pair in multiply or add mode
   function automatic res_t ref_result(input logic [31:0] x, input logic [31:0] y,
                                       input logic s, input logic [4:0] ctrl, input bit add);
      res_t r;
      int   ea, eb, t;
      logic xnan, ynan, xinf, yinf, xzero, yzero, snan_any;
      r    = '0;
      r.ac = ref_class(x);
      r.bc = ref_class(y);
      r.sg = x[31] ^ y[31] ^ (add & s);
      ea   = (x[30:23] == 8'd0) ? 1 : int'(x[30:23]);
      eb   = (y[30:23] == 8'd0) ? 1 : int'(y[30:23]);
      t    = add ? (ea - eb) : (ea + eb - 127);
      r.et = t[9:0];
      r.rm = ctrl[1:0];
      xnan  = (x[30:23] == 8'hFF) && (x[22:0] != 0);
      ynan  = (y[30:23] == 8'hFF) && (y[22:0] != 0);
      xinf  = (x[30:23] == 8'hFF) && (x[22:0] == 0);
      yinf  = (y[30:23] == 8'hFF) && (y[22:0] == 0);
      xzero = (x[30:0] == 31'd0);
      yzero = (y[30:0] == 31'd0);
      snan_any = (xnan && !x[22]) || (ynan && !y[22]);
      if (xnan || ynan) begin
         r.nan = 1'b1;
      end else if (!add && ((xzero && yinf) || (xinf && yzero))) begin
         r.nan = 1'b1;
         r.inv = 1'b1;
      end else if (add && xinf && yinf && r.sg) begin
         r.nan = 1'b1;
         r.inv = 1'b1;
      end else if (xinf || yinf) begin
         r.inf = 1'b1;
      end else if (add ? (xzero && yzero) : (xzero || yzero)) begin
         r.zero = 1'b1;
      end
      if (snan_any) r.inv = 1'b1;
      r.sp = r.nan | r.inf | r.zero;
      return r;
   endfunction

   // Single comparison point: counts and reports
   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Scoreboard: push on accept, pop and compare on output handshake, track stickies
   always @(negedge clk) begin
      exp_t e;
      logic hs;
      if (!rst_n) begin
         sbq.delete();
         m_si_m = 1'b0; m_sn_m = 1'b0; m_si_a = 1'b0; m_sn_a = 1'b0;
         stalled_prev = 1'b0;
         check_output("reset_state", 64'({out_valid_m, out_valid_a, si_m, sn_m, si_a, sn_a}), 64'd0);
      end else begin
         check_output("in_ready_match", 64'(in_ready_a), 64'(in_ready_m));
         check_output("out_valid_match", 64'(out_valid_a), 64'(out_valid_m));
         check_output("sticky", 64'({si_m, sn_m, si_a, sn_a}), 64'({m_si_m, m_sn_m, m_si_a, m_sn_a}));
         if (stalled_prev) begin
            check_output("hold_valid", 64'(out_valid_m), 64'd1);
            check_output("hold_mul", 64'(mul_obs), 64'(prev_mul));
            check_output("hold_add", 64'(add_obs), 64'(prev_add));
         end
         if (in_valid && in_ready_m) begin
            e.mul = ref_result(a, b, sub, control, 1'b0);
            e.add = ref_result(a, b, sub, control, 1'b1);
            sbq.push_back(e);
         end
         hs = out_valid_m & out_ready;
         e  = '0;
         if (hs) begin
            if (sbq.size() == 0) begin
               check_output("no_stale_output", 64'(out_valid_m), 64'd0);
               hs = 1'b0;
            end else begin
               e = sbq.pop_front();
               pops++;
               check_output("result_mul", 64'(mul_obs), 64'(e.mul));
               check_output("result_add", 64'(add_obs), 64'(e.add));
            end
         end
         m_si_m = (m_si_m & ~clr_flags) | (hs & e.mul.inv);
         m_sn_m = (m_sn_m & ~clr_flags) | (hs & e.mul.nan);
         m_si_a = (m_si_a & ~clr_flags) | (hs & e.add.inv);
         m_sn_a = (m_sn_a & ~clr_flags) | (hs & e.add.nan);
         stalled_prev = out_valid_m & ~out_ready;
         prev_mul = mul_obs;
         prev_add = add_obs;
      end
   end

   // Present one operand pair and hold it until the block accepts it
   task automatic apply_stimulus(input logic [31:0] x, input logic [31:0] y,
                                 input logic s, input logic [4:0] ctrl);
      logic acc;
      a = x; b = y; sub = s; control = ctrl; in_valid = 1'b1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         acc = in_ready_m;
         @(posedge clk);
         #1;
         if (acc) return;
      end
      check_output("accept_timeout", 64'(in_ready_m), 64'd1);
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic drain();
      in_valid = 1'b0;
      for (int i = 0; i < 100; i++) begin
         if (sbq.size() == 0) break;
         @(posedge clk);
         #1;
      end
      check_output("drain", 64'(sbq.size()), 64'd0);
   endtask

   initial begin
      int p0;
      pool[0] = 32'h3F800000; pool[1] = 32'h40000000; pool[2] = 32'h00000000;
      pool[3] = 32'h7F800000; pool[4] = 32'hFF800000; pool[5] = 32'h7FC00000;
      pool[6] = 32'h7F800001; pool[7] = 32'h00000001; pool[8] = 32'h80000000;
      pool[9] = 32'hC1200000;
      rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; control = '0;
      out_ready = 1'b1; clr_flags = 1'b0;

      @(negedge clk);
      check_output("reset_outputs_mul", 64'(mul_obs), 64'd0);
      check_output("reset_outputs_add", 64'(add_obs), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_output("ready_after_reset", 64'(in_ready_m), 64'd1);
      @(posedge clk);
      #1;

      // normal x normal
      apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 5'b00001);
      idle(1);
      drain();

      // zero x inf, then clear the sticky flags
      apply_stimulus(32'h00000000, 32'h7F800000, 1'b0, 5'b00010);
      drain();
      @(negedge clk);
      check_output("sticky_inv_set", 64'(si_m), 64'd1);
      check_output("sticky_nan_set", 64'(sn_m), 64'd1);
      @(posedge clk);
      #1 clr_flags = 1'b1;
      @(posedge clk);
      #1 clr_flags = 1'b0;
      @(negedge clk);
      check_output("sticky_cleared", 64'({si_m, sn_m}), 64'd0);
      @(posedge clk);
      #1;

      // clear on the same edge as a setting handshake: the set wins
      apply_stimulus(32'h00000000, 32'h7F800000, 1'b0, 5'b00000);
      in_valid = 1'b0;
      @(posedge clk);
      #1 clr_flags = 1'b1;
      @(posedge clk);
      #1 clr_flags = 1'b0;
      @(negedge clk);
      check_output("set_beats_clear", 64'({si_m, sn_m}), 64'b11);
      @(posedge clk);
      #1;

      // denorm operand, then signalling NaN
      apply_stimulus(32'h00000001, 32'hBF800000, 1'b0, 5'b00011);
      apply_stimulus(32'h7F800001, 32'h3F800000, 1'b0, 5'b00000);
      // inf vs inf with and without subtraction, then 2.0 vs 1.0
      apply_stimulus(32'h7F800000, 32'h7F800000, 1'b1, 5'b00010);
      apply_stimulus(32'h7F800000, 32'h7F800000, 1'b0, 5'b00011);
      apply_stimulus(32'h40000000, 32'h3F800000, 1'b0, 5'b00000);
      drain();

      // backpressure: third input must wait
      p0 = pops;
      out_ready = 1'b0;
      apply_stimulus(32'h3F800000, 32'h3F800000, 1'b0, 5'b00001);
      apply_stimulus(32'h40000000, 32'hC1200000, 1'b1, 5'b00010);
      a = 32'h00000001; b = 32'h7FC00000; sub = 1'b0; control = 5'b00011;
      repeat (3) begin
         @(negedge clk);
         check_output("bp_in_ready_low", 64'(in_ready_m), 64'd0);
         check_output("bp_out_valid", 64'(out_valid_m), 64'd1);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      apply_stimulus(32'h00000001, 32'h7FC00000, 1'b0, 5'b00011);
      drain();
      check_output("bp_count", 64'(pops - p0), 64'd3);

      // reset with two operands in flight
      apply_stimulus(32'h7F800001, 32'h00000000, 1'b0, 5'b00000);
      apply_stimulus(32'h3F800000, 32'h40000000, 1'b0, 5'b00000);
      in_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check_output("midreset_state", 64'({out_valid_m, out_valid_a, si_m, sn_m}), 64'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check_output("ready_after_midreset", 64'(in_ready_m), 64'd1);
      repeat (6) begin
         @(negedge clk);
         check_output("no_output_after_reset", 64'(out_valid_m), 64'd0);
      end
      @(posedge clk);
      #1;

      // random traffic with random stalls and clears
      for (int i = 0; i < 200; i++) begin
         out_ready = ($urandom_range(0, 9) < 7);
         clr_flags = ($urandom_range(0, 9) == 0);
         if (!(in_valid && !in_ready_m)) begin
            in_valid = $urandom_range(0, 3) != 0;
            a        = pool[$urandom_range(0, 9)];
            b        = pool[$urandom_range(0, 9)];
            sub      = 1'($urandom_range(0, 1));
            control  = 5'($urandom_range(0, 31));
         end
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      clr_flags = 1'b0;
      drain();
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
